// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// The winner's operands are held on the ALU for EXEC_CYCLES, then the result is returned tagged with the winner's ID.
module alu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_S,
  output logic [WIDTH-1:0] result,
  output logic             result_id,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_last_id;
  logic             r_ack0;
  logic             r_ack1;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic             r_result_id;
  logic             w_grant;
  logic             w_win;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_grant = 1'b0;
    w_win   = 1'b0;
    if (r_state == IDLE) begin
      if (req0 && req1) begin
        w_grant = 1'b1;
        w_win   = ~r_last_id;
      end else if (req0) begin
        w_grant = 1'b1;
        w_win   = 1'b0;
      end else if (req1) begin
        w_grant = 1'b1;
        w_win   = 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = EXEC;
      EXEC:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    if (result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_last_id   <= 1'b1;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 1'b0;
      r_result    <= '0;
      r_result_id <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_grant) begin
        r_alu_a     <= w_win ? a1 : a0;
        r_alu_b     <= w_win ? b1 : b0;
        r_alu_op    <= w_win ? op1 : op0;
        r_result_id <= w_win;
        r_last_id   <= w_win;
        r_ack0      <= ~w_win;
        r_ack1      <= w_win;
        r_cnt       <= CNT_INIT;
      end else if (r_state == EXEC) begin
        // The ALU output is only trusted after the full settle window.
        if (r_cnt == 4'd0) r_result <= alu_S;
        else               r_cnt    <= r_cnt - 4'd1;
      end
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign alu_A        = r_alu_a;
  assign alu_B        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign result       = r_result;
  assign result_id    = r_result_id;
  assign result_valid = (r_state == DONE);
  assign busy         = (r_state != IDLE);

endmodule
